hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 86 ++++++++
 tb/tb_hazard_scoreboard.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Issue/writeback/status bundle between decode and the hazard scoreboard.
// master = decode side, slave = scoreboard.
interface hazard_scoreboard_if;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_uses_rs1;
  logic        issue_uses_rs2;
  logic [4:0]  issue_rd;
  logic        issue_writes_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic [31:0] pending_mask;
  logic [3:0]  outstanding;
  logic        wb_error;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
    output issue_rd, issue_writes_rd, wb_valid, wb_rd, flush,
    input  stall, pending_mask, outstanding, wb_error
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
    input  issue_rd, issue_writes_rd, wb_valid, wb_rd, flush,
    output stall, pending_mask, outstanding, wb_error
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register pending-write counters gate issue on
// RAW hazards, counter saturation and a global in-flight limit.
module hazard_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  hazard_scoreboard_if.slave   sb
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [3:0]       OutMax = 4'(MAX_OUTSTANDING);

  // Entry 0 exists only to keep indexing simple; it is held at zero.
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [3:0]       outstanding_q, outstanding_d;
  logic             wb_error_q, wb_error_d;

  logic raw, waw_sat, full, rd_tracked;
  logic tracked, wb_hit, wb_miss;

  always_comb begin
    rd_tracked = sb.issue_writes_rd && (sb.issue_rd != 5'd0);
    raw        = (sb.issue_uses_rs1 && (cnt_q[sb.issue_rs1] != '0)) ||
                 (sb.issue_uses_rs2 && (cnt_q[sb.issue_rs2] != '0));
    waw_sat    = rd_tracked && (cnt_q[sb.issue_rd] == CntMax);
    full       = rd_tracked && (outstanding_q == OutMax);
    sb.stall   = sb.issue_valid && (raw || waw_sat || full);
    tracked    = sb.issue_valid && !sb.stall && rd_tracked;
    wb_hit     = sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt_q[sb.wb_rd] != '0);
    wb_miss    = sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt_q[sb.wb_rd] == '0);
  end

  always_comb begin
    cnt_d         = cnt_q;
    outstanding_d = outstanding_q;
    wb_error_d    = wb_error_q || wb_miss;
    if (sb.flush) begin
      for (int i = 0; i < 32; i++) begin
        cnt_d[i] = '0;
      end
      outstanding_d = '0;
    end else begin
      // Same-register issue + writeback nets out to no change.
      if (tracked) begin
        cnt_d[sb.issue_rd] = cnt_d[sb.issue_rd] + CntOne;
      end
      if (wb_hit) begin
        cnt_d[sb.wb_rd] = cnt_d[sb.wb_rd] - CntOne;
      end
      unique case ({tracked, wb_hit})
        2'b10:   outstanding_d = outstanding_q + 4'd1;
        2'b01:   outstanding_d = outstanding_q - 4'd1;
        default: outstanding_d = outstanding_q;
      endcase
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      outstanding_q <= '0;
      wb_error_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      outstanding_q <= outstanding_d;
      wb_error_q    <= wb_error_d;
    end
  end

  always_comb begin
    sb.pending_mask = '0;
    for (int i = 1; i < 32; i++) begin
      sb.pending_mask[i] = |cnt_q[i];
    end
    sb.outstanding = outstanding_q;
    sb.wb_error    = wb_error_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_scoreboard;

  localparam int MaxOut = 4;
  localparam int CntW   = 2;
  localparam int CntSat = (1 << CntW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_scoreboard_if sb ();

  hazard_scoreboard #(
    .MAX_OUTSTANDING(MaxOut),
    .CNT_W          (CntW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sb   (sb)
  );

  typedef struct {
    int          cyc;
    logic        stall;
    logic [31:0] mask;
    logic [3:0]  outs;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   pend[32];
  bit   m_err;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  function automatic int total();
    int s = 0;
    for (int i = 0; i < 32; i++) s += pend[i];
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) pend[i] = 0;
  endfunction

  // One clock cycle: drive inputs, record expected outputs, advance the model.
  task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic wr, input logic wv, input logic [4:0] wrd,
                      input logic fl, input logic rst);
    exp_t e;
    bit   raw, sat, full, trk, hit;
    reset              = rst;
    sb.issue_valid     = v;
    sb.issue_rs1       = rs1;
    sb.issue_uses_rs1  = u1;
    sb.issue_rs2       = rs2;
    sb.issue_uses_rs2  = u2;
    sb.issue_rd        = rd;
    sb.issue_writes_rd = wr;
    sb.wb_valid        = wv;
    sb.wb_rd           = wrd;
    sb.flush           = fl;

    raw  = (u1 && pend[rs1] != 0) || (u2 && pend[rs2] != 0);
    sat  = wr && rd != 0 && pend[rd] == CntSat;
    full = wr && rd != 0 && total() == MaxOut;
    e.cyc   = cyc;
    e.stall = v && (raw || sat || full);
    e.mask  = '0;
    for (int i = 1; i < 32; i++) e.mask[i] = (pend[i] != 0);
    e.outs  = 4'(total());
    e.err   = m_err;
    exp_q.push_back(e);

    if (rst) begin
      model_clear();
      m_err = 0;
    end else begin
      trk = v && !e.stall && wr && rd != 0;
      hit = 0;
      if (wv && wrd != 0) begin
        if (pend[wrd] != 0) hit = 1;
        else m_err = 1;
      end
      if (fl) begin
        model_clear();
      end else begin
        if (trk) pend[rd]++;
        if (hit) pend[wrd]--;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    step(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic check(input string name, input int c, input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stall", e.cyc, 32'(sb.stall), 32'(e.stall));
        check("pending_mask", e.cyc, sb.pending_mask, e.mask);
        check("outstanding", e.cyc, 32'(sb.outstanding), 32'(e.outs));
        check("wb_error", e.cyc, 32'(sb.wb_error), 32'(e.err));
      end
    end
  end

  initial begin : stimulus
    logic       v, u1, u2, wr, wv, fl, rst;
    logic [4:0] rs1, rs2, rd, wrd;
    int         start, idx;
    bit         found;

    reset = 1'b1;
    sb.issue_valid = 0; sb.issue_rs1 = 0; sb.issue_rs2 = 0;
    sb.issue_uses_rs1 = 0; sb.issue_uses_rs2 = 0; sb.issue_rd = 0;
    sb.issue_writes_rd = 0; sb.wb_valid = 0; sb.wb_rd = 0; sb.flush = 0;
    model_clear();
    m_err = 0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, with an issue presented: no stall.
    idle();
    step(1, 5'd3, 1, 5'd4, 1, 5'd6, 1, 0, 0, 0, 1);

    // RAW on rd=5 until the cycle after its writeback.
    issue_wr(5);
    step(1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5'd5, 1, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    step(1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // In-flight limit.
    do_reset();
    for (int r = 1; r <= 4; r++) issue_wr(5'(r));
    issue_wr(6);
    step(1, 5'd10, 1, 5'd11, 1, 0, 0, 0, 0, 0, 0);
    idle();

    // Counter saturation on rd=7.
    do_reset();
    repeat (3) issue_wr(7);
    issue_wr(7);
    step(1, 0, 0, 0, 0, 5'd7, 1, 1, 5'd7, 0, 0);
    issue_wr(7);
    idle();

    // Same-register issue and writeback in one cycle.
    do_reset();
    issue_wr(9);
    step(1, 0, 0, 0, 0, 5'd9, 1, 1, 5'd9, 0, 0);
    idle();

    // Writeback to x0 ignored; stray writeback sticky through flush.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    do_reset();
    idle();

    // Flush overrides a simultaneous issue.
    issue_wr(1);
    issue_wr(2);
    issue_wr(3);
    step(1, 0, 0, 0, 0, 5'd3, 1, 1, 5'd1, 1, 0);
    idle();

    // Mid-operation reset discards pending state.
    issue_wr(8);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0);
    idle();
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199) == 0);
      fl  = ($urandom_range(39) == 0);
      v   = ($urandom_range(3) != 0);
      rs1 = 5'($urandom_range(7));
      rs2 = 5'($urandom_range(7));
      rd  = 5'($urandom_range(7));
      u1  = 1'($urandom_range(1));
      u2  = 1'($urandom_range(1));
      wr  = ($urandom_range(3) != 0);
      wv  = ($urandom_range(2) != 0);
      found = 0;
      wrd   = 0;
      start = $urandom_range(31);
      for (int k = 0; k < 32; k++) begin
        idx = (start + k) % 32;
        if (!found && idx != 0 && pend[idx] != 0) begin
          found = 1;
          wrd   = 5'(idx);
        end
      end
      if (!found || $urandom_range(29) == 0) begin
        wrd = ($urandom_range(9) == 0) ? 5'($urandom_range(31)) : 5'd0;
      end
      step(v, rs1, u1, rs2, u2, rd, wr, wv, wrd, fl, rst);
    end

    idle();
    @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
